// File: rtl/datapath_controller_if.sv
// Instruction handshake and datapath control bundle for datapath_controller.
//   I_INSTR_VALID / I_INSTR / O_INSTR_READY : instruction word valid/ready handshake
//   I_RESUME                                : leave the HALTED state
//   O_DATAPATH_NRESET                       : active-low reset to the datapath
//   O_REG_WRITE_ENABLE                      : one-hot register file write enable
//   O_REG_A_SELECT / O_REG_B_SELECT         : register file read port selects
//   O_IMMEDIATE_SELECT / O_IMMEDIATE        : ALU B operand is the extended immediate
//   O_OPCODE                                : ALU opcode
//   O_BUSY / O_HALTED / O_RETIRED_COUNT     : controller status
// master = instruction source side, slave = controller side.
interface datapath_controller_if;
    logic        I_INSTR_VALID;
    logic [15:0] I_INSTR;
    logic        O_INSTR_READY;
    logic        I_RESUME;
    logic        O_DATAPATH_NRESET;
    logic [15:0] O_REG_WRITE_ENABLE;
    logic [3:0]  O_REG_A_SELECT;
    logic [3:0]  O_REG_B_SELECT;
    logic        O_IMMEDIATE_SELECT;
    logic [15:0] O_IMMEDIATE;
    logic [3:0]  O_OPCODE;
    logic        O_BUSY;
    logic        O_HALTED;
    logic [15:0] O_RETIRED_COUNT;

    modport master (
        output I_INSTR_VALID, I_INSTR, I_RESUME,
        input  O_INSTR_READY, O_DATAPATH_NRESET, O_REG_WRITE_ENABLE,
               O_REG_A_SELECT, O_REG_B_SELECT, O_IMMEDIATE_SELECT,
               O_IMMEDIATE, O_OPCODE, O_BUSY, O_HALTED, O_RETIRED_COUNT
    );

    modport slave (
        input  I_INSTR_VALID, I_INSTR, I_RESUME,
        output O_INSTR_READY, O_DATAPATH_NRESET, O_REG_WRITE_ENABLE,
               O_REG_A_SELECT, O_REG_B_SELECT, O_IMMEDIATE_SELECT,
               O_IMMEDIATE, O_OPCODE, O_BUSY, O_HALTED, O_RETIRED_COUNT
    );
endinterface

// File: rtl/datapath_controller.sv
// Instruction-driven sequencer for the CR16 register file + ALU datapath.
// Holds the datapath in reset for RESET_CYCLES cycles after I_NRESET rises,
// then accepts one 16-bit instruction per two cycles (IDLE -> EXEC -> IDLE),
// decodes register/immediate forms and drives the datapath controls.
// Ports:
//   I_CLK    : clock, rising edge
//   I_NRESET : asynchronous active-low reset
//   bus      : datapath_controller_if.slave (handshake, controls, status)
// Every output is a register loaded from the *_nxt values below.
module datapath_controller #(
    parameter int RESET_CYCLES = 2,
    parameter bit SIGN_EXTEND  = 1'b1
) (
    input  logic                  I_CLK,
    input  logic                  I_NRESET,
    datapath_controller_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_INIT   = 2'd0,
        ST_IDLE   = 2'd1,
        ST_EXEC   = 2'd2,
        ST_HALTED = 2'd3
    } state_t;

    localparam logic [3:0] INIT_LAST = 4'(RESET_CYCLES - 1);

    function automatic logic [15:0] ext_imm(input logic [7:0] v);
        if (SIGN_EXTEND) ext_imm = {{8{v[7]}}, v};
        else             ext_imm = {8'h00, v};
    endfunction

    function automatic logic [15:0] one_hot(input logic [3:0] idx);
        logic [15:0] r;
        r      = '0;
        r[idx] = 1'b1;
        return r;
    endfunction

    state_t      state, state_nxt;
    logic [3:0]  init_cnt, init_cnt_nxt;
    logic        halt_q, halt_nxt;
    logic        nres_q, nres_nxt;
    logic [15:0] we_q, we_nxt;
    logic [3:0]  a_q, a_nxt;
    logic [3:0]  b_q, b_nxt;
    logic        isel_q, isel_nxt;
    logic [15:0] imm_q, imm_nxt;
    logic [3:0]  opc_q, opc_nxt;
    logic [15:0] ret_q, ret_nxt;
    logic        ready_q, busy_q, halted_q;

    logic [3:0]  op, rdest, opext, rsrc;

    assign op    = bus.I_INSTR[15:12];
    assign rdest = bus.I_INSTR[11:8];
    assign opext = bus.I_INSTR[7:4];
    assign rsrc  = bus.I_INSTR[3:0];

    always_comb begin
        state_nxt    = state;
        init_cnt_nxt = init_cnt;
        halt_nxt     = halt_q;
        nres_nxt     = nres_q;
        we_nxt       = '0;
        a_nxt        = a_q;
        b_nxt        = b_q;
        isel_nxt     = isel_q;
        imm_nxt      = imm_q;
        opc_nxt      = opc_q;
        ret_nxt      = ret_q;
        case (state)
            ST_INIT: begin
                if (init_cnt == INIT_LAST) begin
                    state_nxt = ST_IDLE;
                    nres_nxt  = 1'b1;
                end else begin
                    init_cnt_nxt = init_cnt + 4'd1;
                end
            end
            ST_IDLE: begin
                // ready_q is always 1 in IDLE, so valid alone completes the handshake
                if (bus.I_INSTR_VALID) begin
                    state_nxt = ST_EXEC;
                    halt_nxt  = (op == 4'hF);
                    a_nxt     = rdest;
                    b_nxt     = rsrc;
                    imm_nxt   = ext_imm(bus.I_INSTR[7:0]);
                    isel_nxt  = (op != 4'h0) && (op != 4'hF);
                    opc_nxt   = (op == 4'h0) ? opext : op;
                    // write enable is registered here so it is high exactly during EXEC
                    if (op == 4'h0) begin
                        if (opext != 4'h0) we_nxt = one_hot(rdest);
                    end else if (op != 4'hF) begin
                        we_nxt = one_hot(rdest);
                    end
                end
            end
            ST_EXEC: begin
                ret_nxt   = ret_q + 16'd1;
                state_nxt = halt_q ? ST_HALTED : ST_IDLE;
            end
            ST_HALTED: begin
                // a simultaneous valid is ignored; it is seen again in IDLE
                if (bus.I_RESUME) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_INIT;
        endcase
    end

    always_ff @(posedge I_CLK or negedge I_NRESET) begin
        if (!I_NRESET) begin
            state    <= ST_INIT;
            init_cnt <= '0;
            halt_q   <= 1'b0;
            nres_q   <= 1'b0;
            we_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            isel_q   <= 1'b0;
            imm_q    <= '0;
            opc_q    <= '0;
            ret_q    <= '0;
            ready_q  <= 1'b0;
            busy_q   <= 1'b1;
            halted_q <= 1'b0;
        end else begin
            state    <= state_nxt;
            init_cnt <= init_cnt_nxt;
            halt_q   <= halt_nxt;
            nres_q   <= nres_nxt;
            we_q     <= we_nxt;
            a_q      <= a_nxt;
            b_q      <= b_nxt;
            isel_q   <= isel_nxt;
            imm_q    <= imm_nxt;
            opc_q    <= opc_nxt;
            ret_q    <= ret_nxt;
            ready_q  <= (state_nxt == ST_IDLE);
            busy_q   <= (state_nxt != ST_IDLE);
            halted_q <= (state_nxt == ST_HALTED);
        end
    end

    assign bus.O_INSTR_READY      = ready_q;
    assign bus.O_DATAPATH_NRESET  = nres_q;
    assign bus.O_REG_WRITE_ENABLE = we_q;
    assign bus.O_REG_A_SELECT     = a_q;
    assign bus.O_REG_B_SELECT     = b_q;
    assign bus.O_IMMEDIATE_SELECT = isel_q;
    assign bus.O_IMMEDIATE        = imm_q;
    assign bus.O_OPCODE           = opc_q;
    assign bus.O_BUSY             = busy_q;
    assign bus.O_HALTED           = halted_q;
    assign bus.O_RETIRED_COUNT    = ret_q;

endmodule

// File: tb/tb_datapath_controller.sv
// Directed bench for datapath_controller. Two instances share all inputs:
// dut_sx (SIGN_EXTEND=1) and dut_zx (SIGN_EXTEND=0).
module tb_datapath_controller;

    logic        I_CLK = 1'b0;
    logic        I_NRESET = 1'b0;
    logic        valid = 1'b0;
    logic [15:0] instr = 16'h0000;
    logic        resume = 1'b0;

    int total = 0;
    int bad = 0;

    datapath_controller_if bus_sx ();
    datapath_controller_if bus_zx ();

    assign bus_sx.I_INSTR_VALID = valid;
    assign bus_sx.I_INSTR       = instr;
    assign bus_sx.I_RESUME      = resume;
    assign bus_zx.I_INSTR_VALID = valid;
    assign bus_zx.I_INSTR       = instr;
    assign bus_zx.I_RESUME      = resume;

    datapath_controller #(.RESET_CYCLES(2), .SIGN_EXTEND(1'b1)) dut_sx (
        .I_CLK(I_CLK), .I_NRESET(I_NRESET), .bus(bus_sx.slave));
    datapath_controller #(.RESET_CYCLES(2), .SIGN_EXTEND(1'b0)) dut_zx (
        .I_CLK(I_CLK), .I_NRESET(I_NRESET), .bus(bus_zx.slave));

    always #5 I_CLK = ~I_CLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // advance one rising edge and settle just after it
    task automatic tick();
        @(posedge I_CLK);
        #1;
    endtask

    // present a word in IDLE; returns after the accepting edge (start of EXEC)
    task automatic accept(input logic [15:0] w);
        valid = 1'b1;
        instr = w;
        tick();
        valid = 1'b0;
    endtask

    logic [15:0] stream_w  [4];
    logic [15:0] stream_we [4];
    logic [15:0] prev_we;
    logic [15:0] base;

    initial begin
        stream_w[0] = 16'h1101; stream_we[0] = 16'h0002;
        stream_w[1] = 16'h0A32; stream_we[1] = 16'h0400;
        stream_w[2] = 16'h2702; stream_we[2] = 16'h0080;
        stream_w[3] = 16'h3F10; stream_we[3] = 16'h8000;

        // reset, with valid high to show INIT ignores it
        valid = 1'b1;
        instr = 16'h1301;
        tick();
        tick();
        chk("rst_nres", bus_sx.O_DATAPATH_NRESET, 0);
        chk("rst_ready", bus_sx.O_INSTR_READY, 0);
        chk("rst_busy", bus_sx.O_BUSY, 1);
        chk("rst_halted", bus_sx.O_HALTED, 0);
        chk("rst_we", bus_sx.O_REG_WRITE_ENABLE, 0);
        chk("rst_cnt", bus_sx.O_RETIRED_COUNT, 0);
        @(negedge I_CLK);
        I_NRESET = 1'b1;
        tick();
        chk("init1_nres", bus_sx.O_DATAPATH_NRESET, 0);
        chk("init1_ready", bus_sx.O_INSTR_READY, 0);
        tick();
        chk("init2_nres", bus_sx.O_DATAPATH_NRESET, 1);
        chk("init2_ready", bus_sx.O_INSTR_READY, 1);
        chk("init2_busy", bus_sx.O_BUSY, 0);
        chk("init2_we", bus_sx.O_REG_WRITE_ENABLE, 0);
        valid = 1'b0;

        // immediate form, small positive
        accept(16'h1301);
        chk("i1_opc", bus_sx.O_OPCODE, 1);
        chk("i1_asel", bus_sx.O_REG_A_SELECT, 3);
        chk("i1_isel", bus_sx.O_IMMEDIATE_SELECT, 1);
        chk("i1_imm", bus_sx.O_IMMEDIATE, 16'h0001);
        chk("i1_imm_zx", bus_zx.O_IMMEDIATE, 16'h0001);
        chk("i1_we", bus_sx.O_REG_WRITE_ENABLE, 16'h0008);
        chk("i1_ready", bus_sx.O_INSTR_READY, 0);
        tick();
        chk("i1_we_off", bus_sx.O_REG_WRITE_ENABLE, 0);
        chk("i1_cnt", bus_sx.O_RETIRED_COUNT, 1);
        chk("i1_ready2", bus_sx.O_INSTR_READY, 1);

        // immediate form, top bit set
        accept(16'h13FF);
        chk("i2_imm_sx", bus_sx.O_IMMEDIATE, 16'hFFFF);
        chk("i2_imm_zx", bus_zx.O_IMMEDIATE, 16'h00FF);
        tick();
        chk("i2_hold_imm", bus_sx.O_IMMEDIATE, 16'hFFFF);
        chk("i2_cnt", bus_sx.O_RETIRED_COUNT, 2);

        // register form
        accept(16'h0215);
        chk("r_asel", bus_sx.O_REG_A_SELECT, 2);
        chk("r_bsel", bus_sx.O_REG_B_SELECT, 5);
        chk("r_isel", bus_sx.O_IMMEDIATE_SELECT, 0);
        chk("r_opc", bus_sx.O_OPCODE, 1);
        chk("r_we", bus_sx.O_REG_WRITE_ENABLE, 16'h0004);
        tick();
        chk("r_cnt", bus_sx.O_RETIRED_COUNT, 3);

        // NOP
        accept(16'h0200);
        chk("nop_we", bus_sx.O_REG_WRITE_ENABLE, 0);
        tick();
        chk("nop_we2", bus_sx.O_REG_WRITE_ENABLE, 0);
        chk("nop_cnt", bus_sx.O_RETIRED_COUNT, 4);

        // stream of 4 with valid held high
        base = bus_sx.O_RETIRED_COUNT;
        prev_we = 16'h0000;
        valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            instr = stream_w[k];
            tick();
            chk("st_we_acc", bus_sx.O_REG_WRITE_ENABLE, stream_we[k]);
            chk("st_ready_exec", bus_sx.O_INSTR_READY, 0);
            chk("st_consec", 32'((prev_we != 0) && (bus_sx.O_REG_WRITE_ENABLE != 0)), 0);
            prev_we = bus_sx.O_REG_WRITE_ENABLE;
            if (k < 3) instr = stream_w[k+1];
            else valid = 1'b0;
            tick();
            chk("st_we_idle", bus_sx.O_REG_WRITE_ENABLE, 0);
            chk("st_ready_idle", bus_sx.O_INSTR_READY, 1);
            chk("st_cnt", bus_sx.O_RETIRED_COUNT, 32'(base + 16'(k + 1)));
            prev_we = bus_sx.O_REG_WRITE_ENABLE;
        end
        chk("st_total", 32'(bus_sx.O_RETIRED_COUNT - base), 4);

        // HALT, then valid ignored for 10 cycles
        accept(16'hF000);
        chk("h_we", bus_sx.O_REG_WRITE_ENABLE, 0);
        tick();
        chk("h_halted", bus_sx.O_HALTED, 1);
        chk("h_ready", bus_sx.O_INSTR_READY, 0);
        chk("h_busy", bus_sx.O_BUSY, 1);
        chk("h_cnt", bus_sx.O_RETIRED_COUNT, 9);
        valid = 1'b1;
        instr = 16'h1101;
        for (int k = 0; k < 10; k++) begin
            tick();
            chk("h_wait_halted", bus_sx.O_HALTED, 1);
            chk("h_wait_we", bus_sx.O_REG_WRITE_ENABLE, 0);
        end
        chk("h_wait_cnt", bus_sx.O_RETIRED_COUNT, 9);

        // resume with valid also high: resume only
        resume = 1'b1;
        tick();
        resume = 1'b0;
        chk("res_halted", bus_sx.O_HALTED, 0);
        chk("res_ready", bus_sx.O_INSTR_READY, 1);
        chk("res_busy", bus_sx.O_BUSY, 0);
        chk("res_we", bus_sx.O_REG_WRITE_ENABLE, 0);
        tick();
        valid = 1'b0;
        chk("res_acc_we", bus_sx.O_REG_WRITE_ENABLE, 16'h0002);
        tick();
        chk("res_cnt", bus_sx.O_RETIRED_COUNT, 10);

        // reset in the middle of EXEC
        accept(16'h1505);
        chk("mr_we_pre", bus_sx.O_REG_WRITE_ENABLE, 16'h0020);
        I_NRESET = 1'b0;
        #1;
        chk("mr_we", bus_sx.O_REG_WRITE_ENABLE, 0);
        chk("mr_nres", bus_sx.O_DATAPATH_NRESET, 0);
        chk("mr_cnt", bus_sx.O_RETIRED_COUNT, 0);
        chk("mr_imm", bus_sx.O_IMMEDIATE, 0);
        chk("mr_busy", bus_sx.O_BUSY, 1);
        @(negedge I_CLK);
        I_NRESET = 1'b1;
        tick();
        chk("mr_init1_nres", bus_sx.O_DATAPATH_NRESET, 0);
        tick();
        chk("mr_init2_nres", bus_sx.O_DATAPATH_NRESET, 1);
        chk("mr_init2_ready", bus_sx.O_INSTR_READY, 1);
        chk("mr_init2_cnt", bus_sx.O_RETIRED_COUNT, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // safety net so the run always ends
    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end

endmodule
